// File: rtl/sdiv_iter.sv
// Multi-cycle signed divider: restoring radix-2 on magnitudes, one quotient bit per clock, then a sign-fix cycle.
// Optional SDIV_DIV0_SAT_EN: divide-by-zero saturates Q and clears R instead of returning Q=-1, R=A.
module sdiv_iter #(
    parameter int WIDTH = 16,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             REQ,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] D,
    output logic             ACK,
    output logic             BUSY,
    output logic             FDBZ,
    output logic             OVF,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [WIDTH-1:0] ZERO_VAL = '0;
    localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] MAX_VAL  = {1'b0, {(WIDTH-1){1'b1}}};

    logic [1:0]       r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_dvd;    // dividend magnitude; quotient bits shift in from the LSB end
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH-1:0] r_rem;
    logic             r_sign_q;
    logic             r_sign_r;
    logic             r_ack;
    logic             r_busy;
    logic             r_fdbz;
    logic             r_ovf;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_r;

    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_d_mag;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;
    logic             w_ge;
    logic             w_div0;
    logic             w_ovf;
    logic [WIDTH-1:0] w_z_q;
    logic [WIDTH-1:0] w_z_r;

    // |MIN| wraps back to MIN, which read as unsigned is exactly 2^(WIDTH-1).
    assign w_a_mag = A[WIDTH-1] ? (ZERO_VAL - A) : A;
    assign w_d_mag = D[WIDTH-1] ? (ZERO_VAL - D) : D;

    // The shifted remainder is always below 2^WIDTH, so the top bit of the
    // WIDTH+1-bit difference is a clean borrow.
    assign w_shift = {r_rem, r_dvd[WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, r_dvs};
    assign w_ge    = ~w_diff[WIDTH];

    assign w_div0 = (D == ZERO_VAL);
    assign w_ovf  = (A == MIN_VAL) && (D == {WIDTH{1'b1}});

`ifdef SDIV_DIV0_SAT_EN
    assign w_z_q = A[WIDTH-1] ? MIN_VAL : MAX_VAL;
    assign w_z_r = ZERO_VAL;
`else
    assign w_z_q = {WIDTH{1'b1}};
    assign w_z_r = A;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_dvd    <= '0;
            r_dvs    <= '0;
            r_rem    <= '0;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_ack    <= 1'b0;
            r_busy   <= 1'b0;
            r_fdbz   <= 1'b0;
            r_ovf    <= 1'b0;
            r_q      <= '0;
            r_r      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_ack <= 1'b0;
                    if (REQ) begin
                        r_sign_q <= A[WIDTH-1] ^ D[WIDTH-1];
                        r_sign_r <= A[WIDTH-1];
                        r_dvd    <= w_a_mag;
                        r_dvs    <= w_d_mag;
                        r_rem    <= '0;
                        r_cnt    <= CW'(WIDTH);
                        if (w_div0) begin
                            r_fdbz  <= 1'b1;
                            r_ovf   <= 1'b0;
                            r_q     <= w_z_q;
                            r_r     <= w_z_r;
                            r_state <= S_DONE;
                        end else if (w_ovf) begin
                            r_fdbz  <= 1'b0;
                            r_ovf   <= 1'b1;
                            r_q     <= MIN_VAL;
                            r_r     <= ZERO_VAL;
                            r_state <= S_DONE;
                        end else begin
                            r_busy  <= 1'b1;
                            r_state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (!REQ) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_rem <= w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
                        r_dvd <= {r_dvd[WIDTH-2:0], w_ge};
                        r_cnt <= r_cnt - CW'(1);
                        if (r_cnt == CW'(1)) begin
                            r_state <= S_FIX;
                        end
                    end
                end
                S_FIX: begin
                    r_busy <= 1'b0;
                    if (!REQ) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_q     <= r_sign_q ? (ZERO_VAL - r_dvd) : r_dvd;
                        r_r     <= r_sign_r ? (ZERO_VAL - r_rem) : r_rem;
                        r_fdbz  <= 1'b0;
                        r_ovf   <= 1'b0;
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    // Results are held here; only REQ falling returns to IDLE.
                    if (REQ) begin
                        r_ack <= 1'b1;
                    end else begin
                        r_ack   <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign ACK  = r_ack;
    assign BUSY = r_busy;
    assign FDBZ = r_fdbz;
    assign OVF  = r_ovf;
    assign Q    = r_q;
    assign R    = r_r;

endmodule
